// File: rtl/dbg_cmd_dispatch.sv
// Debug command dispatcher: brings TCK-side updates into clk and issues them to cores.
// Optional cmd_count counter enabled by defining DBG_CMD_COUNT_EN.
module dbg_cmd_dispatch #(
    parameter int NUM_CORES      = 2,
    parameter int IR_W           = 2,
    parameter int DR_W           = 38,
    parameter int SEL_W          = 2,
    parameter int SYNC_STAGES    = 2,
    parameter int ACTION_BIT     = 36,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 udr_async,
    input  logic [IR_W-1:0]      ir_async,
    input  logic [DR_W-1:0]      sr_async,
    input  logic [SEL_W-1:0]     sel_async,
    input  logic [NUM_CORES-1:0] cmd_ready,
    input  logic                 clear_err,
    output logic [DR_W-1:0]      jdo,
    output logic [IR_W-1:0]      cmd_ir,
    output logic                 cmd_action,
    output logic [NUM_CORES-1:0] cmd_valid,
    output logic                 busy,
    output logic                 overrun_err,
    output logic                 timeout_err,
    output logic                 sel_err,
    output logic [NUM_CORES-1:0] timeout_mask,
    output logic [15:0]          cmd_count
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t               state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                 udr_q;
    logic                 udr_rise;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_CORES-1:0] valid_d, mask_d, sel_hit, pend;
    logic [DR_W-1:0]      jdo_d;
    logic [IR_W-1:0]      ir_d;
    logic                 action_d, ovr_d, to_d, sel_d;

    assign udr_rise = sync_q[SYNC_STAGES-1] & ~udr_q;
    assign busy     = (state_q == ISSUE);
    assign pend     = cmd_valid & ~cmd_ready;

    always_comb begin
        sel_hit = '0;
        unique case (1'b1)
            (&sel_async):                   sel_hit = {NUM_CORES{1'b1}};
            (int'(sel_async) < NUM_CORES):  sel_hit = NUM_CORES'(1) << sel_async;
            default:                        sel_hit = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        valid_d  = cmd_valid;
        jdo_d    = jdo;
        ir_d     = cmd_ir;
        action_d = cmd_action;
        cnt_d    = cnt_q;
        ovr_d    = overrun_err & ~clear_err;
        to_d     = timeout_err & ~clear_err;
        sel_d    = sel_err & ~clear_err;
        mask_d   = clear_err ? '0 : timeout_mask;
        unique case (state_q)
            IDLE: begin
                if (udr_rise) begin
                    jdo_d    = sr_async;
                    ir_d     = ir_async;
                    action_d = ~sr_async[ACTION_BIT];
                    if (|sel_hit) begin
                        valid_d = sel_hit;
                        cnt_d   = '0;
                        state_d = ISSUE;
                    end else begin
                        sel_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (udr_rise)
                    ovr_d = 1'b1;
                valid_d = pend;
                cnt_d   = cnt_q + 1'b1;
                if (pend == '0) begin
                    state_d = IDLE;
                end else if (TO_EN && cnt_q == TO_LAST) begin
                    // cores that acked this cycle are excluded from the mask
                    mask_d  = pend;
                    valid_d = '0;
                    to_d    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            sync_q       <= '0;
            udr_q        <= 1'b0;
            cnt_q        <= '0;
            cmd_valid    <= '0;
            jdo          <= '0;
            cmd_ir       <= '0;
            cmd_action   <= 1'b0;
            overrun_err  <= 1'b0;
            timeout_err  <= 1'b0;
            sel_err      <= 1'b0;
            timeout_mask <= '0;
        end else begin
            state_q      <= state_d;
            sync_q       <= {sync_q[SYNC_STAGES-2:0], udr_async};
            udr_q        <= sync_q[SYNC_STAGES-1];
            cnt_q        <= cnt_d;
            cmd_valid    <= valid_d;
            jdo          <= jdo_d;
            cmd_ir       <= ir_d;
            cmd_action   <= action_d;
            overrun_err  <= ovr_d;
            timeout_err  <= to_d;
            sel_err      <= sel_d;
            timeout_mask <= mask_d;
        end
    end

`ifdef DBG_CMD_COUNT_EN
    logic [15:0] count_q;
    logic        issue_enter;

    assign issue_enter = (state_q == IDLE) && (state_d == ISSUE);
    assign cmd_count   = count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            count_q <= '0;
        else if (issue_enter && count_q != 16'hFFFF)
            count_q <= count_q + 16'd1;
    end
`else
    assign cmd_count = 16'h0000;
`endif

endmodule

// File: tb/tb_dbg_cmd_dispatch.sv
// Directed self-checking bench for dbg_cmd_dispatch (NUM_CORES=2, SYNC_STAGES=2, TIMEOUT_CYCLES=8).
module tb_dbg_cmd_dispatch;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        udr_async;
    logic [1:0]  ir_async;
    logic [37:0] sr_async;
    logic [1:0]  sel_async;
    logic [1:0]  cmd_ready;
    logic        clear_err;
    logic [37:0] jdo;
    logic [1:0]  cmd_ir;
    logic        cmd_action;
    logic [1:0]  cmd_valid;
    logic        busy;
    logic        overrun_err;
    logic        timeout_err;
    logic        sel_err;
    logic [1:0]  timeout_mask;
    logic [15:0] cmd_count;

    int checks   = 0;
    int failures = 0;
    int accepted = 0;

    always #5 clk = ~clk;

    dbg_cmd_dispatch #(
        .NUM_CORES(2), .IR_W(2), .DR_W(38), .SEL_W(2),
        .SYNC_STAGES(2), .ACTION_BIT(36), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .reset_n(reset_n), .udr_async(udr_async),
        .ir_async(ir_async), .sr_async(sr_async), .sel_async(sel_async),
        .cmd_ready(cmd_ready), .clear_err(clear_err), .jdo(jdo),
        .cmd_ir(cmd_ir), .cmd_action(cmd_action), .cmd_valid(cmd_valid),
        .busy(busy), .overrun_err(overrun_err), .timeout_err(timeout_err),
        .sel_err(sel_err), .timeout_mask(timeout_mask), .cmd_count(cmd_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise udr with the given fields; returns just after the capture edge.
    task automatic send(input logic [1:0] sel, input logic [1:0] ir, input logic [37:0] sr);
        sel_async = sel;
        ir_async  = ir;
        sr_async  = sr;
        udr_async = 1'b1;
        repeat (3) tick();
        udr_async = 1'b0;
    endtask

    initial begin
        reset_n   = 1'b0;
        udr_async = 1'b0;
        ir_async  = '0;
        sr_async  = '0;
        sel_async = '0;
        cmd_ready = '0;
        clear_err = 1'b0;
        repeat (2) tick();
        chk("rst_valid", 64'(cmd_valid), 64'h0);
        chk("rst_jdo", 64'(jdo), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_errs", 64'({overrun_err, timeout_err, sel_err}), 64'h0);
        chk("rst_count", 64'(cmd_count), 64'h0);
        reset_n = 1'b1;
        repeat (2) tick();

        // single-core command, ready[0] held high
        cmd_ready = 2'b01;
        send(2'd0, 2'b10, 38'h00_0000_1234);
        accepted++;
        chk("single_valid", 64'(cmd_valid), 64'h1);
        chk("single_jdo", 64'(jdo), 64'h00_0000_1234);
        chk("single_action", 64'(cmd_action), 64'h1);
        chk("single_ir", 64'(cmd_ir), 64'h2);
        chk("single_busy", 64'(busy), 64'h1);
        tick();
        chk("single_clr", 64'(cmd_valid), 64'h0);
        chk("single_busy_off", 64'(busy), 64'h0);
        cmd_ready = 2'b00;
        repeat (3) tick();

        // broadcast with bit36 set
        send(2'b11, 2'b01, 38'h10_0000_0055);
        accepted++;
        chk("bc_valid", 64'(cmd_valid), 64'h3);
        chk("bc_action", 64'(cmd_action), 64'h0);
        repeat (2) tick();
        cmd_ready = 2'b10;
        tick();
        chk("bc_part", 64'(cmd_valid), 64'h1);
        chk("bc_busy", 64'(busy), 64'h1);
        cmd_ready = 2'b00;
        tick();
        cmd_ready = 2'b01;
        tick();
        chk("bc_done", 64'(cmd_valid), 64'h0);
        chk("bc_idle", 64'(busy), 64'h0);
        cmd_ready = 2'b00;
        repeat (3) tick();

        // invalid select
        send(2'b10, 2'b00, 38'h0_0000_0777);
        chk("sel_err", 64'(sel_err), 64'h1);
        chk("sel_valid", 64'(cmd_valid), 64'h0);
        chk("sel_busy", 64'(busy), 64'h0);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        chk("sel_clr", 64'(sel_err), 64'h0);
        repeat (3) tick();

        // timeout: core 1 never ready
        send(2'd1, 2'b11, 38'h0_0000_00AA);
        accepted++;
        chk("to_v0", 64'(cmd_valid), 64'h2);
        for (int i = 1; i < 8; i++) begin
            tick();
            chk($sformatf("to_v%0d", i), 64'(cmd_valid), 64'h2);
        end
        tick();
        chk("to_clr", 64'(cmd_valid), 64'h0);
        chk("to_err", 64'(timeout_err), 64'h1);
        chk("to_mask", 64'(timeout_mask), 64'h2);
        chk("to_busy", 64'(busy), 64'h0);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        chk("to_err_clr", 64'(timeout_err), 64'h0);
        chk("to_mask_clr", 64'(timeout_mask), 64'h0);
        repeat (3) tick();

        // overrun: second update while busy is dropped
        send(2'd0, 2'b01, 38'h2A_5A5A_A5A5);
        accepted++;
        chk("ov_first", 64'(cmd_valid), 64'h1);
        chk("ov_first_act", 64'(cmd_action), 64'h1);
        repeat (2) tick();
        send(2'd1, 2'b10, 38'h00_0000_003F);
        chk("ov_err", 64'(overrun_err), 64'h1);
        chk("ov_jdo", 64'(jdo), 64'h2A_5A5A_A5A5);
        chk("ov_valid", 64'(cmd_valid), 64'h1);
        chk("ov_ir", 64'(cmd_ir), 64'h1);
        cmd_ready = 2'b01;
        tick();
        chk("ov_done", 64'(cmd_valid), 64'h0);
        cmd_ready = 2'b00;
        repeat (2) tick();
        send(2'd0, 2'b11, 38'h1_2345_6789);
        accepted++;
        chk("ov_third_v", 64'(cmd_valid), 64'h1);
        chk("ov_third_jdo", 64'(jdo), 64'h1_2345_6789);
        cmd_ready = 2'b01;
        tick();
        chk("ov_third_clr", 64'(cmd_valid), 64'h0);
        cmd_ready = 2'b00;
        tick();

`ifdef DBG_CMD_COUNT_EN
        chk("count", 64'(cmd_count), 64'(accepted));
`else
        chk("count", 64'(cmd_count), 64'h0);
`endif

        // reset in the middle of ISSUE drops valids asynchronously
        repeat (2) tick();
        send(2'b11, 2'b00, 38'h0_0000_0001);
        chk("mid_valid", 64'(cmd_valid), 64'h3);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(cmd_valid), 64'h0);
        chk("mid_rst_errs", 64'({overrun_err, timeout_err, sel_err}), 64'h0);
        chk("mid_rst_busy", 64'(busy), 64'h0);
        tick();
        reset_n = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
